// File: rtl/self_destruct_ctrl.sv
// Self-destruct controller: strobe generation, fault/combat debouncing, K-of-N vote and armed countdown FSM.
// Build option SDC_BLINK_EN: display blinks all-ones/0 on every tick while DETONATED.
module self_destruct_ctrl #(
  parameter int N_CH       = 3,
  parameter int VOTE_K     = 2,
  parameter int DEB_DIV    = 60000,
  parameter int DEB_CYCLES = 4,
  parameter int TICK_DIV   = 3000000,
  parameter int CNT_W      = 4,
  parameter int COUNT_MAX  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   fault_raw,
  input  logic              combat_raw,
  input  logic              abort,
  output logic [N_CH-1:0]   fault_deb,
  output logic              critical,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  display,
  output logic              detonate
);

  localparam int DDIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int TDIV_W = $clog2(TICK_DIV);
  localparam int NDEB   = N_CH + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_COUNTING  = 2'd2,
    ST_DETONATED = 2'd3
  } state_t;

  logic [DDIV_W-1:0] deb_div_q;
  logic              deb_stb;
  logic [TDIV_W-1:0] tick_div_q;
  logic              tick;
  logic [NDEB-1:0]   raw_q;
  logic [NDEB-1:0]   deb_out_q;
  logic [NDEB-1:0]   deb_out_d;
  logic [3:0]        deb_cnt_q [NDEB];
  logic [3:0]        deb_cnt_d [NDEB];
  logic [4:0]        pop_count;
  logic              critical_d;
  logic              critical_q;
  logic              combat_deb;
  logic              exit_req;
  logic              arm_to_count;
  logic [CNT_W-1:0]  det_display;
  state_t            state_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  display_q;
  logic              detonate_q;

  assign deb_stb = (deb_div_q == DDIV_W'(DEB_DIV - 1));
  assign tick    = (tick_div_q == TDIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || deb_stb) begin
      deb_div_q <= '0;
    end else begin
      deb_div_q <= deb_div_q + DDIV_W'(1);
    end
  end

  // Raw switches are captured once per clock before the debouncers see them.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q <= '0;
    end else begin
      raw_q <= {combat_raw, fault_raw};
    end
  end

  always_comb begin
    deb_out_d = deb_out_q;
    for (int i = 0; i < NDEB; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (deb_stb) begin
        if (raw_q[i] != deb_out_q[i]) begin
          if (deb_cnt_q[i] + 4'd1 == 4'(DEB_CYCLES)) begin
            deb_out_d[i] = raw_q[i];
            deb_cnt_d[i] = 4'd0;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
          end
        end else begin
          deb_cnt_d[i] = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_out_q <= '0;
      for (int i = 0; i < NDEB; i++) begin
        deb_cnt_q[i] <= 4'd0;
      end
    end else begin
      deb_out_q <= deb_out_d;
      for (int i = 0; i < NDEB; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign fault_deb  = deb_out_q[N_CH-1:0];
  assign combat_deb = deb_out_q[N_CH];

  always_comb begin
    pop_count = 5'd0;
    for (int i = 0; i < N_CH; i++) begin
      pop_count = pop_count + 5'(deb_out_q[i]);
    end
    critical_d = (pop_count >= 5'(VOTE_K));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      critical_q <= 1'b0;
    end else begin
      critical_q <= critical_d;
    end
  end

  assign exit_req     = abort || !combat_deb;
  assign arm_to_count = (state_q == ST_ARMED) && !exit_req && critical_q;

  // Restarting the divider on entry to COUNTING makes the first tick land a full period later.
  always_ff @(posedge clk) begin
    if (reset || arm_to_count || tick) begin
      tick_div_q <= '0;
    end else begin
      tick_div_q <= tick_div_q + TDIV_W'(1);
    end
  end

`ifdef SDC_BLINK_EN
  logic blink_q;

  always_ff @(posedge clk) begin
    if (reset || (state_q != ST_DETONATED)) begin
      blink_q <= 1'b1;
    end else if (tick) begin
      blink_q <= ~blink_q;
    end
  end

  assign det_display = blink_q ? '1 : '0;
`else
  assign det_display = '1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      display_q  <= '0;
      detonate_q <= 1'b0;
    end else begin
      display_q <= (state_q == ST_DETONATED) ? det_display : count_q;
      case (state_q)
        ST_IDLE: begin
          count_q <= '0;
          if (combat_deb && !abort) begin
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (exit_req) begin
            state_q <= ST_IDLE;
            count_q <= '0;
          end else if (critical_q) begin
            state_q <= ST_COUNTING;
          end
        end
        ST_COUNTING: begin
          if (exit_req) begin
            state_q <= ST_IDLE;
            count_q <= '0;
          end else if (tick && critical_q) begin
            if (count_q == CNT_W'(COUNT_MAX - 1)) begin
              count_q    <= CNT_W'(COUNT_MAX);
              state_q    <= ST_DETONATED;
              detonate_q <= 1'b1;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        ST_DETONATED: begin
          count_q    <= CNT_W'(COUNT_MAX);
          detonate_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign critical = critical_q;
  assign state    = state_q;
  assign count    = count_q;
  assign display  = display_q;
  assign detonate = detonate_q;

endmodule

// File: doc/self_destruct_ctrl.md
Name: self_destruct_ctrl

Overview:
Parametrised successor to the robot self-destruct chain. It combines on-chip strobe generation, per-channel debouncing of N fault inputs, a K-of-N critical vote and an armed countdown state machine with abort, in one clocked block. It drives the countdown display and a sticky detonate flag to the top level. Width, channel count, vote threshold, debounce depth and countdown limit are all parameters.

Parameters:
N_CH, 3, number of fault input channels (1..16)
VOTE_K, 2, critical asserted when at least VOTE_K debounced faults are high (1..N_CH)
DEB_DIV, 60000, clk cycles per debounce sample strobe (>=1)
DEB_CYCLES, 4, consecutive differing samples needed to flip a debounced output (1..15)
TICK_DIV, 3000000, clk cycles per countdown tick (>=2)
CNT_W, 4, countdown/display width
COUNT_MAX, 10, terminal count (1..2^CNT_W-2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fault_raw  in  N_CH  raw fault switches (danger/damaged/immobilised...)
combat_raw  in  1  raw in-combat switch; arms the block
abort  in  1  synchronous, already clean; returns to IDLE unless DETONATED
fault_deb  out  N_CH  debounced faults
critical  out  1  registered K-of-N vote
state  out  2  0 IDLE, 1 ARMED, 2 COUNTING, 3 DETONATED
count  out  CNT_W  current countdown value
display  out  CNT_W  LED value
detonate  out  1  sticky, high in DETONATED

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state updates on posedge clk only.
- Reset: fault_deb=0, combat_deb=0, critical=0, state=IDLE, count=0, display=0, detonate=0, all dividers=0. Reset mid-countdown or in DETONATED gives the same result.
- Sample strobe: deb_stb pulses for 1 clk every DEB_DIV clks. Free-running.
- Debouncer (one per fault channel plus one for combat_raw):
  - On each deb_stb, a sample that differs from the output increments a per-channel counter.
  - A matching sample clears the counter.
  - When the counter reaches DEB_CYCLES, the output flips and the counter clears.
  - Samples between strobes are ignored.
- critical: registered popcount(fault_deb) >= VOTE_K. It lags fault_deb by 1 clk.
- Tick: tick pulses for 1 clk every TICK_DIV clks. The tick divider is cleared on the ARMED->COUNTING transition, so the first tick arrives exactly TICK_DIV clks after entry.
- FSM (priority: reset > DETONATED hold > abort > combat_deb low > other):
  - IDLE: count=0. Goes to ARMED when combat_deb=1 and abort=0.
  - ARMED: goes to COUNTING when critical=1.
  - COUNTING: on tick with critical=1, count increments.
    - On tick with critical=0, count holds (pause). It does not return to ARMED.
    - When count==COUNT_MAX-1 and an incrementing tick occurs, count becomes COUNT_MAX and the next state is DETONATED.
  - ARMED/COUNTING exits: abort=1 or combat_deb=0 goes to IDLE next clk, with count cleared in the same update.
  - DETONATED: absorbing state. Ignores abort, combat and faults; count frozen at COUNT_MAX; detonate=1. Only reset exits.
- Count never exceeds COUNT_MAX and never wraps.
- display: registered, 1 clk behind count.
  - display=count in IDLE, ARMED and COUNTING.
  - display=all-ones in DETONATED (see optional feature).
- Simultaneous events:
  - abort with the terminal tick: abort wins, state goes to IDLE.
  - combat_deb falling with critical rising in ARMED: goes to IDLE.

Optional Feature:
SDC_BLINK_EN
- Defined: in DETONATED, display toggles between all-ones and 0 on every tick, starting at all-ones. The tick divider keeps running in DETONATED.
- Undefined: display holds constant all-ones in DETONATED; no blink logic is synthesised.
- detonate and count are identical in both builds.

Test Plan:
All scenarios use N_CH=3, VOTE_K=2, DEB_DIV=2, DEB_CYCLES=4, TICK_DIV=8, COUNT_MAX=10, CNT_W=4.
1. Debounce: fault_raw[0] glitches high for 5 clks, then held high 20 clks -> fault_deb[0] stays 0 for the glitch; it rises 7-9 clks after the stable edge; critical stays 0 (only 1 of 3 faults).
2. Vote: combat_raw=1, then fault_raw=3'b101 -> critical=1 one clk after the second fault_deb rises; state goes ARMED->COUNTING; count=1 exactly 8 clks after entering COUNTING.
3. Pause: during COUNTING at count=4, drop fault_raw to 3'b001 for 40 clks -> count holds at 4 and state stays 2. Restore 3'b011 -> counting resumes at 5.
4. Detonate: hold critical -> after 10 ticks count=10, state=3, detonate=1, display=4'hF. Then abort=1 and combat_raw=0 -> no change.
5. Abort/reset: abort pulsed at count=7 -> next clk state=0, count=0, then display=0. Separately, reset in DETONATED -> all outputs 0 on the next clk.
6. SDC_BLINK_EN defined: after detonate, display sequence per tick is F,0,F,0. Undefined: display stays F.
